// File: rtl/sdram_pkg.sv
// Shared encodings, field widths and sequencer state for the SDRAM command path.
// Linear word address layout: bank in the top bits, then row, then column.
package sdram_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 24;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
    } sdram_addr_t;

    function automatic sdram_addr_t split_addr(input logic [ADDR_W-1:0] p);
        sdram_addr_t a;
        a.bank = p[23:22];
        a.row  = p[21:9];
        a.col  = p[8:0];
        return a;
    endfunction

endpackage

// File: rtl/sdram_seq_fifo.sv
// First-word-fall-through write buffer: head always shows the oldest word.
// DEPTH must be a power of two so the indices wrap on their own.
module sdram_seq_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_idx_reg;
    logic [AW-1:0]     rd_idx_reg;
    logic [LW-1:0]     level_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_idx_reg <= wr_idx_reg + AW'(1);
            end
            if (pop) begin
                rd_idx_reg <= rd_idx_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head  = mem[rd_idx_reg];
    assign level = level_reg;
    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);

endmodule

// File: rtl/sdram_sequencer.sv
// Buffers log words and issues one-word read/write commands to sdram_interface.
// `SDRAM_SEQ_WRAP_EN turns the write pointer into a ring instead of stopping at the top.
module sdram_sequencer
    import sdram_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int CMD_TIMEOUT_CYC = 64,
    // Power-on write address; nonzero only for bring-up of the end-of-memory path.
    parameter logic [ADDR_W-1:0] WR_PTR_INIT = '0
) (
    input  logic              CLK_48MHZ,
    input  logic              RESET,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_BUSY,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_DONE,
    output logic [1:0]        CMD_OUT,
    output logic [BANK_W-1:0] A_BANK,
    output logic [ROW_W-1:0]  A_ROW,
    output logic [COL_W-1:0]  A_COL,
    output logic [DATA_W-1:0] D_OUT,
    input  logic              SDRAM_STATUS,
    input  logic [DATA_W-1:0] SDRAM_DATA,
    output logic [ADDR_W-1:0] WR_PTR,
    output logic [6:0]        FIFO_LEVEL,
    output logic              MEM_FULL,
    output logic              CMD_ERR
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(CMD_TIMEOUT_CYC + 1);

    seq_state_t        state_reg, state_next;
    logic              op_write_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [1:0]        cmd_reg;
    sdram_addr_t       addr_reg;
    logic [DATA_W-1:0] dout_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic              rd_busy_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_done_reg;
    logic              cmd_err_reg;
    logic              mem_full;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;

    logic sel_write, sel_read, timeout;
    logic issue_write, issue_read, ack, expire, done;

    sdram_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (CLK_48MHZ),
        .reset_n   (RESET),
        .push      (fifo_push),
        .push_data (WR_DATA),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign WR_READY  = RESET & ~fifo_full & ~mem_full;
    assign fifo_push = WR_VALID & WR_READY;
    assign fifo_pop  = ack & op_write_reg;

    // In IDLE no read is in flight, so a busy flag means a read is waiting.
    assign sel_write = ~fifo_empty & ~mem_full &
                       (~rd_busy_reg | (fifo_level >= LVL_W'(FIFO_DEPTH / 2)));
    assign sel_read  = rd_busy_reg & ~sel_write;
    assign timeout   = (to_cnt_reg == TO_W'(CMD_TIMEOUT_CYC - 1));

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!SDRAM_STATUS && (sel_write || sel_read)) state_next = ISSUE;
            ISSUE:   if (SDRAM_STATUS) state_next = WAIT;
                     else if (timeout) state_next = IDLE;
            WAIT:    if (!SDRAM_STATUS) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue_write = 1'b0;
        issue_read  = 1'b0;
        ack         = 1'b0;
        expire      = 1'b0;
        done        = 1'b0;
        case (state_reg)
            IDLE: begin
                issue_write = ~SDRAM_STATUS & sel_write;
                issue_read  = ~SDRAM_STATUS & sel_read;
            end
            ISSUE: begin
                ack    = SDRAM_STATUS;
                expire = ~SDRAM_STATUS & timeout;
            end
            WAIT:    done = ~SDRAM_STATUS;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            op_write_reg <= 1'b0;
            to_cnt_reg   <= '0;
            cmd_reg      <= CMD_IDLE;
            addr_reg     <= '0;
            dout_reg     <= '0;
            rd_addr_reg  <= '0;
            rd_busy_reg  <= 1'b0;
            rd_data_reg  <= '0;
            rd_done_reg  <= 1'b0;
            cmd_err_reg  <= 1'b0;
        end else begin
            rd_done_reg <= 1'b0;
            if (issue_write) begin
                cmd_reg      <= CMD_WRITE;
                addr_reg     <= split_addr(wr_ptr_reg);
                dout_reg     <= fifo_head;
                op_write_reg <= 1'b1;
                to_cnt_reg   <= '0;
            end else if (issue_read) begin
                cmd_reg      <= CMD_READ;
                addr_reg     <= split_addr(rd_addr_reg);
                op_write_reg <= 1'b0;
                to_cnt_reg   <= '0;
            end else if (ack || expire) begin
                cmd_reg <= CMD_IDLE;
            end else if (state_reg == ISSUE) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
            if (expire) begin
                cmd_err_reg <= 1'b1;
            end
            if (!rd_busy_reg && RD_REQ) begin
                rd_addr_reg <= RD_ADDR;
                rd_busy_reg <= 1'b1;
            end
            if (done && !op_write_reg) begin
                rd_data_reg <= SDRAM_DATA;
                rd_done_reg <= 1'b1;
                rd_busy_reg <= 1'b0;
            end
        end
    end

`ifdef SDRAM_SEQ_WRAP_EN
    assign mem_full = 1'b0;

    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_reg <= WR_PTR_INIT;
        end else if (done && op_write_reg) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
        end
    end
`else
    logic mem_full_reg;

    // The last address is written once; the pointer then parks and logging stops.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_reg   <= WR_PTR_INIT;
            mem_full_reg <= 1'b0;
        end else if (done && op_write_reg) begin
            if (&wr_ptr_reg) begin
                mem_full_reg <= 1'b1;
            end else begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
        end
    end

    assign mem_full = mem_full_reg;
`endif

    assign CMD_OUT    = cmd_reg;
    assign A_BANK     = addr_reg.bank;
    assign A_ROW      = addr_reg.row;
    assign A_COL      = addr_reg.col;
    assign D_OUT      = dout_reg;
    assign RD_BUSY    = rd_busy_reg;
    assign RD_DATA    = rd_data_reg;
    assign RD_DONE    = rd_done_reg;
    assign WR_PTR     = wr_ptr_reg;
    assign FIFO_LEVEL = 7'(fifo_level);
    assign MEM_FULL   = mem_full;
    assign CMD_ERR    = cmd_err_reg;

endmodule

// File: doc/sdram_sequencer.md
# sdram_sequencer

Upstream command stage for `sdram_interface`. It buffers 16-bit data words from the avionics logging path and walks a linear 24-bit word pointer across bank, row and column. It issues one-word write or read commands over the `CMD_IN`/`STATUS` handshake and returns read-back data to a dump/telemetry requester.

## Interface
- `FIFO_DEPTH`, 16: write-buffer depth in words; power of two, 4..64.
- `CMD_TIMEOUT_CYC`, 64: cycles to wait for `STATUS` to rise after a command is presented.
- `CLK_48MHZ`  in  1  system clock; all logic on the rising edge.
- `RESET`  in  1  reset, asynchronous, active-low.
- `WR_DATA`  in  16  word to log.
- `WR_VALID`  in  1  `WR_DATA` valid.
- `WR_READY`  out  1  word accepted when `WR_VALID & WR_READY`.
- `RD_REQ`  in  1  read request; sampled only while `RD_BUSY=0`.
- `RD_ADDR`  in  24  linear word address for the read.
- `RD_BUSY`  out  1  a read is pending or in flight.
- `RD_DATA`  out  16  read result; held until the next read completes.
- `RD_DONE`  out  1  one-cycle pulse when `RD_DATA` updates.
- `CMD_OUT`  out  2  goes to `CMD_IN`: 0 = idle, 1 = read, 2 = write.
- `A_BANK` / `A_ROW` / `A_COL`  out  2/13/9  go to `A_IN_BANK` / `A_IN_ROW` / `A_IN_COL`.
- `D_OUT`  out  16  goes to `D_IN`.
- `SDRAM_STATUS`  in  1  comes from `STATUS` (busy).
- `SDRAM_DATA`  in  16  comes from `DATA_READ`.
- `WR_PTR`  out  24  next linear write address.
- `FIFO_LEVEL`  out  7  words buffered.
- `MEM_FULL`  out  1  sticky; memory exhausted.
- `CMD_ERR`  out  1  sticky; a command timeout occurred.

## Operation
- Address map: linear address `p`. `A_COL=p[8:0]`, `A_ROW=p[21:9]`, `A_BANK=p[23:22]`.
- `WR_READY = !fifo_full & !MEM_FULL`. It is forced to 0 while `RESET` is low.
- States are IDLE, ISSUE and WAIT.
- **IDLE.** The block waits for `SDRAM_STATUS=0`. This also covers the power-up/init period, while `STATUS` is held high. It then arbitrates:
  - Write is selected if the FIFO is non-empty and either no read is pending or `FIFO_LEVEL >= FIFO_DEPTH/2`.
  - Otherwise a pending read is selected.
- **IDLE → ISSUE.** Address and data outputs are registered on this transition:
  - Write: `CMD_OUT=2`, `D_OUT`=FIFO head, address=`WR_PTR`.
  - Read: `CMD_OUT=1`, address=latched `RD_ADDR`.
- **ISSUE.** `CMD_OUT` and the address/data outputs are held constant.
  - On the first cycle with `SDRAM_STATUS=1`: `CMD_OUT←0`, go to WAIT. A write also pops the FIFO on that edge.
  - If `SDRAM_STATUS` stays 0 for `CMD_TIMEOUT_CYC` cycles: `CMD_OUT←0`, set `CMD_ERR`, go to IDLE. Nothing is popped, and the same operation is re-arbitrated.
- **WAIT.** On the first cycle with `SDRAM_STATUS=0`:
  - Write: `WR_PTR←WR_PTR+1` (24-bit).
  - Read: `RD_DATA←SDRAM_DATA`, `RD_DONE=1` for one cycle, `RD_BUSY←0`.
  - Then go to IDLE.
- **Read request.** `RD_REQ` is accepted when `RD_BUSY=0`. `RD_ADDR` is latched and `RD_BUSY←1` on the same edge.
- **Simultaneous events.** A FIFO push and pop in the same cycle leave `FIFO_LEVEL` unchanged. A push to a full FIFO cannot occur, because `WR_READY=0`.
- **Reset values.** All outputs are 0: `CMD_OUT`, address outputs, `D_OUT`, `RD_DATA`, `RD_DONE`, `RD_BUSY`, `WR_PTR`, `FIFO_LEVEL`, `MEM_FULL`, `CMD_ERR`.
- **Reset mid-operation.** FIFO contents are discarded and the state returns to IDLE on the next clock after `RESET` rises.

## Timing
- Write latency: from accept to `CMD_OUT=2`, at least 2 cycles when IDLE with `STATUS=0`.
- `CMD_OUT` returns to 0 exactly 1 cycle after `STATUS` is sampled high.
- `RD_DONE` fires 1 cycle after `STATUS` is sampled low in WAIT.
- Minimum command spacing is 1 IDLE cycle between WAIT exit and the next ISSUE.
- The downstream block samples `CMD_IN` on the falling edge. All outputs here are registered on the rising edge, which gives half a cycle of setup.

## Configuration
- `SDRAM_SEQ_WRAP_EN`
  - Defined: `WR_PTR` wraps from 0xFFFFFF to 0 and logging continues (ring buffer). `MEM_FULL` is tied to 0.
  - Undefined: the write that increments `WR_PTR` from 0xFFFFFF sets `MEM_FULL` and holds `WR_PTR` at 0xFFFFFF. `WR_READY` then stays 0 until reset. Reads remain available.

## Structure
- Package `sdram_pkg` holds:
  - command encodings: `CMD_IDLE=0`, `CMD_READ=1`, `CMD_WRITE=2`;
  - widths: bank 2, row 13, col 9, data 16, linear address 24;
  - the state enum: IDLE/ISSUE/WAIT.
- Sub-module `sdram_seq_fifo` is a synchronous first-word-fall-through FIFO parameterised by `FIFO_DEPTH`. It provides push, pop, head, level and full/empty, with an asynchronous active-low reset.

## Test plan
- Power-up: `STATUS=1` for 100 cycles with `WR_VALID=1` and data 0xA5A5. `CMD_OUT` stays 0 and `FIFO_LEVEL` rises to `FIFO_DEPTH`. After `STATUS` falls, the first write shows `CMD_OUT=2`, `D_OUT=0xA5A5`, bank/row/col 0/0/0.
- Write sequence: three words 0x0001..0x0003 with the model busy for 12 cycles each. Commands are issued to column 0, 1, 2 and `WR_PTR` ends at 3. Each `CMD_OUT=2` lasts until 1 cycle after `STATUS` rises.
- Read: `RD_REQ` with `RD_ADDR=0x400201`. The outputs are `CMD_OUT=1`, `A_BANK=1`, `A_ROW=1`, `A_COL=1`. The model returns 0xBEEF, after which `RD_DATA=0xBEEF`, `RD_DONE` pulses once and `RD_BUSY` clears.
- Arbitration: with `FIFO_LEVEL=FIFO_DEPTH/2` and a read pending, the write goes first. With level 1 and a read pending, the read goes first.
- Timeout: the model never raises `STATUS`. After 64 cycles `CMD_OUT=0`, `CMD_ERR=1` and the FIFO level is unchanged. The retry succeeds once the model responds.
- Wrap: preload `WR_PTR=0xFFFFFF` and write one word. With the macro: `WR_PTR=0`, `MEM_FULL=0`. Without it: `MEM_FULL=1`, `WR_READY=0`, `WR_PTR=0xFFFFFF`.
